// File: rtl/epcs_pkg.sv
// Shared opcodes and encodings for the EPCS flash-emulating SPI responder.
package epcs_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_RDID = 8'hAB;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } state_t;

  typedef enum logic [1:0] {
    SRC_MEM,
    SRC_STATUS,
    SRC_ID
  } src_t;

endpackage

// File: rtl/epcs_spi_responder_if.sv
// SPI pins, read-memory port and status hooks of the EPCS responder.
interface epcs_spi_responder_if #(
  parameter int unsigned ADDR_WIDTH = 16
);

  logic                  spi_sck_i;
  logic                  spi_cs_n_i;
  logic                  spi_mosi_i;
  logic                  spi_miso_o;
  logic                  spi_miso_oe;
  logic                  mem_rd_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [7:0]            mem_data_i;
  logic [7:0]            status_i;
  logic                  active_o;

  modport slave (
    input  spi_sck_i, spi_cs_n_i, spi_mosi_i, mem_data_i, status_i,
    output spi_miso_o, spi_miso_oe, mem_rd_o, mem_addr_o, active_o
  );

  modport master (
    output spi_sck_i, spi_cs_n_i, spi_mosi_i, mem_data_i, status_i,
    input  spi_miso_o, spi_miso_oe, mem_rd_o, mem_addr_o, active_o
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for a group of level inputs plus one edge-detected input
// whose rise/fall pulses are taken between the second and third stage.
module spi_sync_edge #(
  parameter int unsigned    LW      = 1,
  parameter logic [LW-1:0]  LVL_RST = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          edge_i,
  input  logic [LW-1:0] level_i,
  output logic [LW-1:0] level_o,
  output logic          rise_o,
  output logic          fall_o
);

  logic [LW-1:0] lvl1_q, lvl2_q;
  logic          edg1_q, edg2_q, edg3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lvl1_q <= LVL_RST;
      lvl2_q <= LVL_RST;
      edg1_q <= 1'b0;
      edg2_q <= 1'b0;
      edg3_q <= 1'b0;
    end else begin
      lvl1_q <= level_i;
      lvl2_q <= lvl1_q;
      edg1_q <= edge_i;
      edg2_q <= edg1_q;
      edg3_q <= edg2_q;
    end
  end

  assign level_o = lvl2_q;
  assign rise_o  = edg2_q & ~edg3_q;
  assign fall_o  = ~edg2_q & edg3_q;

endmodule

// File: rtl/epcs_spi_responder.sv
// EPCS flash stand-in: oversampled SPI target answering READ, READ STATUS and
// READ SILICON ID, with read data fetched from an external synchronous byte memory.
module epcs_spi_responder
  import epcs_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter logic [7:0]  SILICON_ID  = 8'h14,
  parameter int unsigned DUMMY_BYTES = 3
) (
  input logic                 clock,
  input logic                 reset_n,
  epcs_spi_responder_if.slave bus
);

  localparam int unsigned DUMMY_BITS = DUMMY_BYTES * 8;
  localparam int unsigned CNT_MAX    = (DUMMY_BITS > 24) ? DUMMY_BITS : 24;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX);
  localparam int unsigned AQ_W       = ADDR_WIDTH - 1;

  logic [1:0] lvl_s;
  logic       sck_rise, sck_fall, cs_n_s, mosi_s;

  spi_sync_edge #(
    .LW      (2),
    .LVL_RST (2'b01)
  ) u_sync (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .edge_i  (bus.spi_sck_i),
    .level_i ({bus.spi_mosi_i, bus.spi_cs_n_i}),
    .level_o (lvl_s),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  assign cs_n_s = lvl_s[0];
  assign mosi_s = lvl_s[1];

  state_t                state_q, state_d;
  src_t                  src_q, src_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [6:0]            cmd_q, cmd_d;
  logic [AQ_W-1:0]       addr_q, addr_d;
  logic [7:0]            shift_q, shift_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  miso_q, miso_d;
  logic                  oe_q, oe_d;
  logic                  rd_q, rd_d;
  logic                  load_q, load_d;
  logic                  active_q, active_d;
  logic [7:0]            opcode;

  // The 8th opcode bit is still on the synchronised MOSI line at decode time.
  assign opcode = {cmd_q, mosi_s};

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    mem_addr_d = mem_addr_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    active_d   = active_q;
    rd_d       = 1'b0;
    load_d     = rd_q;

    if (cs_n_s) begin
      // Deselect wins over any SCK edge seen in the same cycle.
      state_d  = ST_CMD;
      cnt_d    = '0;
      oe_d     = 1'b0;
      miso_d   = 1'b0;
      active_d = 1'b0;
      load_d   = 1'b0;
    end else begin
      oe_d = 1'b1;
      // Memory returns data the cycle after the strobe, so capture one cycle later.
      if (load_q && state_q == ST_DATA && src_q == SRC_MEM) shift_d = bus.mem_data_i;

      if (sck_rise) begin
        unique case (state_q)
          ST_CMD: begin
            cmd_d = opcode[6:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
              cnt_d = '0;
              if (opcode == OP_READ) begin
                state_d  = ST_ADDR;
                active_d = 1'b1;
              end else if (opcode == OP_RDSR) begin
                state_d  = ST_DATA;
                src_d    = SRC_STATUS;
                shift_d  = bus.status_i;
                active_d = 1'b1;
              end else if (opcode == OP_RDID) begin
                active_d = 1'b1;
                if (DUMMY_BYTES == 0) begin
                  state_d = ST_DATA;
                  src_d   = SRC_ID;
                  shift_d = SILICON_ID;
                end else begin
                  state_d = ST_DUMMY;
                end
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
          ST_ADDR: begin
            addr_d = {addr_q[AQ_W-2:0], mosi_s};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(23)) begin
              cnt_d      = '0;
              mem_addr_d = {addr_q, mosi_s};
              rd_d       = 1'b1;
              state_d    = ST_DATA;
              src_d      = SRC_MEM;
            end
          end
          ST_DUMMY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DUMMY_BITS - 1)) begin
              cnt_d   = '0;
              state_d = ST_DATA;
              src_d   = SRC_ID;
              shift_d = SILICON_ID;
            end
          end
          default: ;
        endcase
      end

      if (sck_fall && state_q == ST_DATA) begin
        miso_d  = shift_q[7];
        shift_d = {shift_q[6:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(7)) begin
          cnt_d = '0;
          unique case (src_q)
            SRC_MEM: begin
              mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
              rd_d       = 1'b1;
            end
            SRC_STATUS: shift_d = bus.status_i;
            default:    shift_d = SILICON_ID;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CMD;
      src_q      <= SRC_MEM;
      cnt_q      <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      shift_q    <= '0;
      mem_addr_q <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      rd_q       <= 1'b0;
      load_q     <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      mem_addr_q <= mem_addr_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      rd_q       <= rd_d;
      load_q     <= load_d;
      active_q   <= active_d;
    end
  end

  assign bus.spi_miso_o  = miso_q;
  assign bus.spi_miso_oe = oe_q;
  assign bus.mem_rd_o    = rd_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.active_o    = active_q;

endmodule

// File: tb/tb_epcs_spi_responder.sv
// Bench for epcs_spi_responder: mode-0 SPI master, byte memory model, scoreboards.
`timescale 1ns/1ps
module tb_epcs_spi_responder;
  import epcs_pkg::*;

  localparam int unsigned AW   = 16;
  localparam int unsigned HALF = 8;
  localparam int unsigned NV   = 7;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  epcs_spi_responder_if #(.ADDR_WIDTH(AW)) bus ();

  epcs_spi_responder #(
    .ADDR_WIDTH  (AW),
    .SILICON_ID  (8'h14),
    .DUMMY_BYTES (3)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [7:0]      op;
    logic [23:0]     addr;
    logic [3:0]      nbytes;
    logic [7:0]      st0;
    logic [7:0]      st1;
    logic [3:0][7:0] exp;     // exp[0] is the first byte out
    logic            chk_act;
    logic            act;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;
  logic [7:0]    exp_q[$];
  logic [AW-1:0] addr_q[$];
  vec_t          tbl[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Synchronous byte memory: content is a[7:0] ^ 8'hA5.
  always @(posedge clock)
    if (bus.mem_rd_o) bus.mem_data_i <= bus.mem_addr_o[7:0] ^ 8'hA5;

  always @(negedge clock) begin
    if (reset_n && bus.mem_rd_o) begin
      rd_cnt++;
      check("rd_while_cs_high", {31'b0, bus.spi_cs_n_i}, 32'd0);
      if (addr_q.size() == 0) check("rd_unexpected", {31'b0, bus.mem_rd_o}, 32'd0);
      else                    check("rd_addr", {16'b0, bus.mem_addr_o}, {16'b0, addr_q.pop_front()});
    end
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      bus.spi_sck_i  = 1'b0;
      bus.spi_mosi_i = tx[7-i];
      wait_clk(HALF);
      bus.spi_sck_i = 1'b1;
      rx = {rx[6:0], bus.spi_miso_o};
      wait_clk(HALF);
    end
  endtask

  task automatic cs_begin();
    bus.spi_sck_i  = 1'b0;
    bus.spi_cs_n_i = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_end();
    bus.spi_sck_i = 1'b0;
    wait_clk(HALF);
    bus.spi_cs_n_i = 1'b1;
    wait_clk(6);
  endtask

  function automatic vec_t mk(input logic [7:0] op, input logic [23:0] addr, input logic [3:0] n,
                              input logic [7:0] st0, input logic [7:0] st1,
                              input logic [31:0] exp, input logic chk_act, input logic act);
    vec_t v;
    v.op = op; v.addr = addr; v.nbytes = n; v.st0 = st0; v.st1 = st1;
    v.exp = exp; v.chk_act = chk_act; v.act = act;
    return v;
  endfunction

  initial begin
    logic [7:0] rx;
    vec_t t;

    tbl[0] = mk(OP_READ, 24'h000010, 4'd4, 8'h00, 8'h00, 32'hB6B7B4B5, 1'b1, 1'b1);
    tbl[1] = mk(OP_READ, 24'h00FFFE, 4'd3, 8'h00, 8'h00, 32'h00A55A5B, 1'b1, 1'b1);
    tbl[2] = mk(OP_RDSR, 24'h000000, 4'd2, 8'h01, 8'h03, 32'h00000301, 1'b0, 1'b0);
    tbl[3] = mk(OP_RDID, 24'h000000, 4'd2, 8'h00, 8'h00, 32'h00001414, 1'b1, 1'b1);
    tbl[4] = mk(8'h42,   24'h000000, 4'd2, 8'h00, 8'h00, 32'h00000000, 1'b1, 1'b0);
    tbl[5] = mk(OP_READ, 24'h000000, 4'd1, 8'h00, 8'h00, 32'h000000A5, 1'b1, 1'b1);
    tbl[6] = mk(OP_READ, 24'h120020, 4'd1, 8'h00, 8'h00, 32'h00000085, 1'b1, 1'b1);

    bus.spi_sck_i  = 1'b0;
    bus.spi_cs_n_i = 1'b1;
    bus.spi_mosi_i = 1'b0;
    bus.status_i   = 8'h00;
    bus.mem_data_i = 8'h00;

    wait_clk(3);
    check("rst_miso",   {31'b0, bus.spi_miso_o},  32'd0);
    check("rst_oe",     {31'b0, bus.spi_miso_oe}, 32'd0);
    check("rst_rd",     {31'b0, bus.mem_rd_o},    32'd0);
    check("rst_addr",   {16'b0, bus.mem_addr_o},  32'd0);
    check("rst_active", {31'b0, bus.active_o},    32'd0);
    reset_n = 1'b1;
    wait_clk(4);

    for (int v = 0; v < NV; v++) begin
      t = tbl[v];
      rd_cnt = 0;
      bus.status_i = t.st0;
      if (t.op == OP_READ)
        for (int b = 0; b <= int'(t.nbytes); b++) addr_q.push_back(AW'(t.addr) + AW'(b));
      cs_begin();
      xfer_bits(t.op, 8, rx);
      wait_clk(4);
      bus.status_i = t.st1;
      if (t.op == OP_READ) begin
        xfer_bits(t.addr[23:16], 8, rx);
        xfer_bits(t.addr[15:8], 8, rx);
        xfer_bits(t.addr[7:0], 8, rx);
      end else if (t.op == OP_RDID) begin
        for (int d = 0; d < 3; d++) xfer_bits(8'hFF, 8, rx);
      end
      for (int b = 0; b < int'(t.nbytes); b++) begin
        exp_q.push_back(t.exp[b]);
        xfer_bits(8'h00, 8, rx);
        check($sformatf("v%0d_byte%0d", v, b), {24'b0, rx}, {24'b0, exp_q.pop_front()});
      end
      check($sformatf("v%0d_oe_on", v), {31'b0, bus.spi_miso_oe}, 32'd1);
      if (t.chk_act) check($sformatf("v%0d_active", v), {31'b0, bus.active_o}, {31'b0, t.act});
      cs_end();
      check($sformatf("v%0d_oe_off", v), {31'b0, bus.spi_miso_oe}, 32'd0);
      check($sformatf("v%0d_act_off", v), {31'b0, bus.active_o}, 32'd0);
      check($sformatf("v%0d_miso_off", v), {31'b0, bus.spi_miso_o}, 32'd0);
      check($sformatf("v%0d_rd_count", v), rd_cnt, (t.op == OP_READ) ? int'(t.nbytes) + 1 : 0);
      addr_q.delete();
    end

    // Deselect after 12 address bits, then a clean READ at 0x000020.
    rd_cnt = 0;
    cs_begin();
    xfer_bits(OP_READ, 8, rx);
    xfer_bits(8'h00, 8, rx);
    xfer_bits(8'h00, 4, rx);
    cs_end();
    check("abort_rd_count", rd_cnt, 0);
    check("abort_active", {31'b0, bus.active_o}, 32'd0);
    addr_q.push_back(16'h0020);
    addr_q.push_back(16'h0021);
    cs_begin();
    xfer_bits(OP_READ, 8, rx);
    xfer_bits(8'h00, 8, rx);
    xfer_bits(8'h00, 8, rx);
    xfer_bits(8'h20, 8, rx);
    xfer_bits(8'h00, 8, rx);
    check("after_abort_byte", {24'b0, rx}, 32'h85);
    cs_end();
    check("after_abort_rd_count", rd_cnt, 2);
    addr_q.delete();

    // Asynchronous reset in the middle of a DATA phase.
    addr_q.push_back(16'h0040);
    addr_q.push_back(16'h0041);
    cs_begin();
    xfer_bits(OP_READ, 8, rx);
    xfer_bits(8'h00, 8, rx);
    xfer_bits(8'h00, 8, rx);
    xfer_bits(8'h40, 8, rx);
    xfer_bits(8'h00, 8, rx);
    check("pre_rst_byte", {24'b0, rx}, 32'hE5);
    wait_clk(2);
    check("pre_rst_active", {31'b0, bus.active_o}, 32'd1);
    check("pre_rst_addr", {16'b0, bus.mem_addr_o}, 32'h41);
    check("pre_rst_miso", {31'b0, bus.spi_miso_o}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_miso",   {31'b0, bus.spi_miso_o},  32'd0);
    check("arst_oe",     {31'b0, bus.spi_miso_oe}, 32'd0);
    check("arst_rd",     {31'b0, bus.mem_rd_o},    32'd0);
    check("arst_addr",   {16'b0, bus.mem_addr_o},  32'd0);
    check("arst_active", {31'b0, bus.active_o},    32'd0);
    addr_q.delete();
    wait_clk(2);
    reset_n = 1'b1;
    cs_end();
    check("post_rst_oe", {31'b0, bus.spi_miso_oe}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
